// File: rtl/turn_ctrl.sv
// Chess game-flow controller: turn select, clock run-enable, flag-fall and move count.
// Define TURN_CTRL_DEBOUNCE_EN to synchronize and debounce the push-buttons.
module turn_ctrl #(
  parameter int DIGIT_W         = 5,
  parameter int MOVE_CNT_W      = 10,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         start_btn,
  input  logic                         pause_btn,
  input  logic                         move_done,
  input  logic [3:0][DIGIT_W-1:0]      timer_status_black,
  input  logic [3:0][DIGIT_W-1:0]      timer_status_white,
  output logic                         turn,
  output logic                         clock_run,
  output logic                         game_over,
  output logic                         winner,
  output logic [MOVE_CNT_W-1:0]        move_count,
  output logic [1:0]                   state_out
);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] RUN   = 2'b01;
  localparam logic [1:0] PAUSE = 2'b10;
  localparam logic [1:0] OVER  = 2'b11;

  localparam logic [MOVE_CNT_W-1:0] CNT_MAX = '1;

  // Bit 0 = start, bit 1 = pause.
  logic [1:0] btn_raw;
  logic [1:0] btn_lvl;

  assign btn_raw = {pause_btn, start_btn};

`ifdef TURN_CTRL_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]         sync1_q;
  logic [1:0]         sync2_q;
  logic [1:0]         db_q;
  logic [1:0][CW-1:0] db_cnt_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // Counter runs only while the synced level differs from the
  // debounced one; any return to the old level restarts it.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      db_q     <= '0;
      db_cnt_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] != db_q[i]) begin
          if (db_cnt_q[i] == DB_LAST) begin
            db_q[i]     <= sync2_q[i];
            db_cnt_q[i] <= '0;
          end else begin
            db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
          end
        end else begin
          db_cnt_q[i] <= '0;
        end
      end
    end
  end

  assign btn_lvl = db_q;

  logic unused_ok;
  assign unused_ok = ^{timer_status_black, timer_status_white};
`else
  assign btn_lvl = btn_raw;

  logic unused_ok;
  assign unused_ok = ^{timer_status_black, timer_status_white,
                       DEBOUNCE_CYCLES[0]};
`endif

  logic [1:0] hist_q;
  logic [1:0] pulse_q;
  logic       start_p;
  logic       pause_p;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hist_q  <= '0;
      pulse_q <= '0;
    end else begin
      hist_q  <= btn_lvl;
      pulse_q <= btn_lvl & ~hist_q;
    end
  end

  assign start_p = pulse_q[0];
  assign pause_p = pulse_q[1];

  logic [1:0]            state_q, state_d;
  logic                  turn_q, turn_d;
  logic                  run_q, run_d;
  logic                  over_q, over_d;
  logic                  win_q, win_d;
  logic [MOVE_CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0][DIGIT_W-1:0] act_bus;
  logic                    flag_active;

  assign act_bus = turn_q ? timer_status_black : timer_status_white;

  // Only the BCD nibble of each slot counts.
  always_comb begin
    flag_active = 1'b1;
    for (int d = 0; d < 4; d++) begin
      if (act_bus[d][3:0] != 4'd0) flag_active = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    turn_d  = turn_q;
    over_d  = over_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start_p) state_d = RUN;
      end
      RUN: begin
        if (flag_active) begin
          state_d = OVER;
          over_d  = 1'b1;
          win_d   = ~turn_q;
        end else begin
          if (move_done) begin
            turn_d = ~turn_q;
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
          end
          if (pause_p) state_d = PAUSE;
        end
      end
      PAUSE: begin
        if (start_p || pause_p) state_d = RUN;
      end
      default: begin
        state_d = OVER;
      end
    endcase
    run_d = (state_d == RUN);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      turn_q  <= 1'b0;
      run_q   <= 1'b0;
      over_q  <= 1'b0;
      win_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      turn_q  <= turn_d;
      run_q   <= run_d;
      over_q  <= over_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
    end
  end

  assign turn       = turn_q;
  assign clock_run  = run_q;
  assign game_over  = over_q;
  assign winner     = win_q;
  assign move_count = cnt_q;
  assign state_out  = state_q;

endmodule

// File: doc/turn_ctrl.md
Name: turn_ctrl

Overview:
- Game-flow controller directly upstream of the chess clock counter.
- Produces the `turn` select and a run-enable that the clock counter consumes.
- Reads back both players' BCD time digits to detect flag-fall (time expired) and declare game over with a winner.
- Sits between the move-commit logic / push-buttons and the clock counter.

Parameters:
- DIGIT_W, 5, width of each BCD digit slot in the timer status buses (low 4 bits hold the BCD value).
- MOVE_CNT_W, 10, width of the move counter.
- DEBOUNCE_CYCLES, 500000, stable-level cycles required by the optional debouncer (10 ms at 50 MHz).

Ports:
- Clk  in  1  system clock, 50 MHz.
- Reset  in  1  asynchronous, active-high reset.
- start_btn  in  1  start/resume request, level.
- pause_btn  in  1  pause toggle request, level.
- move_done  in  1  one-cycle pulse from move-commit logic: current player finished a legal move.
- timer_status_black  in  4x DIGIT_W  black clock digits; [3] is MSD, [0] is LSD.
- timer_status_white  in  4x DIGIT_W  white clock digits.
- turn  out  1  0 = white to move, 1 = black to move.
- clock_run  out  1  high while the active player's clock may count down.
- game_over  out  1  sticky; high once a flag has fallen.
- winner  out  1  valid when game_over: 0 = white wins, 1 = black wins.
- move_count  out  MOVE_CNT_W  number of completed moves (plies).
- state_out  out  2  current FSM state encoding, for debug and display.

Behaviour:
- Reset (asynchronous, active-high): all registers clear immediately.
  - Reset values: state=IDLE, turn=0, clock_run=0, game_over=0, winner=0, move_count=0, edge-detect history=0.
  - A reset asserted mid-game aborts the game with no further outputs.
- Button inputs: rising-edge detected against a 1-cycle registered history; each press yields one internal pulse (start_p, pause_p). Holding a button gives exactly one pulse.
- FSM states, encodings and transitions:
  - IDLE (00): start_p -> RUN.
  - RUN (01): pause_p -> PAUSE. Flag detected -> OVER. move_done -> stay in RUN and toggle turn.
  - PAUSE (10): start_p or pause_p -> RUN. move_done is ignored.
  - OVER (11): terminal until Reset; all inputs ignored.
- clock_run = 1 only in RUN; registered, so it follows the state register in the same cycle.
- Flag detection:
  - flag_active = all four digits of the active player's bus (selected by the current turn) have low 4 bits equal to 0.
  - Evaluated only in RUN.
  - On detection: next cycle state=OVER, game_over=1, winner=~turn, clock_run=0.
- move_done in RUN, no flag in the same cycle:
  - turn <= ~turn next cycle.
  - move_count <= move_count+1, saturating at all-ones (no wrap).
- Simultaneous events:
  - Flag and move_done in the same cycle: flag wins; turn and move_count are unchanged.
  - pause_p and move_done in the same cycle in RUN: both take effect (turn toggles and state -> PAUSE).
  - start_p and pause_p in the same cycle in IDLE: -> RUN.
- Latency: input pulse to output change is 1 cycle (2 cycles from the raw button level via the edge detector).
- Zero digits while IDLE or PAUSE never flag.
- Upper bit of each DIGIT_W slot is ignored.

Optional Feature:
- Macro: TURN_CTRL_DEBOUNCE_EN.
- Defined:
  - start_btn and pause_btn each pass through a 2-flop synchronizer.
  - Then a per-button debouncer: the counter resets on any level change; the debounced level updates only after DEBOUNCE_CYCLES consecutive stable cycles.
  - Edge detection acts on the debounced level.
  - Debouncer state clears on Reset.
- Undefined: raw inputs feed the edge detector directly (caller guarantees synchronous, clean levels).

Test Plan:
- Reset, then start_btn high 3 cycles -> state=01, clock_run=1 two cycles after the rise, exactly one transition; turn=0, move_count=0.
- In RUN, three move_done pulses spaced 5 cycles apart -> turn toggles 0->1->0->1, move_count=3.
- In RUN with turn=1, drive black digits {0,0,0,0}, white {2,0,0,0} -> next cycle state=11, game_over=1, winner=0, clock_run=0; later move_done and start_btn produce no change.
- In RUN, turn=0, white digits go to 0 in the same cycle as move_done -> game_over=1, winner=1, turn stays 0, move_count unchanged.
- pause_btn press -> state=10, clock_run=0; zero digits and move_done ignored while paused; second pause_btn press -> RUN.
- Force move_count=1023 (MOVE_CNT_W=10), pulse move_done -> stays 1023; Reset asserted asynchronously mid-RUN -> all outputs 0 without waiting for a clock edge.
